// File: rtl/mem_dados_ctrl.sv
// Byte-addressed data memory with valid/ready request/response handshake,
// configurable read latency, access-fault detection and halt-time PC capture.
module mem_dados_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        halt,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_saved,
  output logic        pc_saved_valid
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_halt_q;
  logic [DATA_W-1:0]  r_pc_saved;
  logic               r_pc_saved_valid;

  logic               w_accept;
  logic [ADDR_W-1:0]  w_idx;
  logic               w_oor;
  logic               w_misalign;
  logic               w_err;
  logic [3:0]         w_be;
  logic [DATA_W-1:0]  w_wlane;
  logic [DATA_W-1:0]  w_rword;
  logic [DATA_W-1:0]  w_rshift;
  logic [DATA_W-1:0]  w_rext;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_idx    = req_addr[ADDR_W+1:2];
  assign w_oor    = |req_addr[31:ADDR_W+2];
  assign w_err    = w_oor || w_misalign;

  // Byte-lane enables, replicated write data and alignment check per access size
  always_comb begin
    w_be       = 4'b0000;
    w_wlane    = req_wdata;
    w_misalign = 1'b0;
    case (req_size)
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wlane = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be       = 4'b0011 << {req_addr[1], 1'b0};
        w_wlane    = {2{req_wdata[15:0]}};
        w_misalign = req_addr[0];
      end
      2'b10: begin
        w_be       = 4'b1111;
        w_misalign = |req_addr[1:0];
      end
      default: w_misalign = 1'b1;
    endcase
  end

  // Lane extraction and sign/zero extension of the word read at acceptance
  assign w_rword  = r_mem[w_idx];
  assign w_rshift = w_rword >> {req_addr[1:0], 3'b000};

  always_comb begin
    w_rext = '0;
    case (req_size)
      2'b00:   w_rext = req_unsigned ? {24'h0, w_rshift[7:0]}
                                     : {{24{w_rshift[7]}}, w_rshift[7:0]};
      2'b01:   w_rext = req_unsigned ? {16'h0, w_rshift[15:0]}
                                     : {{16{w_rshift[15]}}, w_rshift[15:0]};
      2'b10:   w_rext = w_rshift;
      default: w_rext = '0;
    endcase
  end

  // Storage is deliberately not reset; writes commit on the acceptance edge
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (RD_LAT <= 1) ? ST_RESP : ST_WAIT;
          w_cnt_nxt   = CNT_W'(RD_LAT - 1);
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Response payload is latched at acceptance and held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_rdata <= (req_we || w_err) ? '0 : w_rext;
      r_rsp_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halt_q         <= 1'b0;
      r_pc_saved       <= '0;
      r_pc_saved_valid <= 1'b0;
    end else begin
      r_halt_q <= halt;
      if (halt && !r_halt_q) begin
        r_pc_saved       <= pc_cur;
        r_pc_saved_valid <= 1'b1;
      end
    end
  end

  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_err        = r_rsp_err;
  assign pc_saved       = r_pc_saved;
  assign pc_saved_valid = r_pc_saved_valid;

endmodule

// File: tb/tb_mem_dados_ctrl.sv
// Bench for mem_dados_ctrl: two instances (RD_LAT 1 and 3) checked every cycle
// against a byte-array reference model, plus directed literal expectations.
module tb_mem_dados_ctrl;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_we, req_unsigned;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata, pc_cur, pc_saved;
  logic [1:0][1:0]  req_size;
  logic [1:0]       rsp_valid, rsp_ready, rsp_err, halt, pc_saved_valid;

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_dados_ctrl #(.ADDR_W(6), .RD_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid[g]),
      .req_ready      (req_ready[g]),
      .req_we         (req_we[g]),
      .req_addr       (req_addr[g]),
      .req_size       (req_size[g]),
      .req_unsigned   (req_unsigned[g]),
      .req_wdata      (req_wdata[g]),
      .rsp_valid      (rsp_valid[g]),
      .rsp_ready      (rsp_ready[g]),
      .rsp_rdata      (rsp_rdata[g]),
      .rsp_err        (rsp_err[g]),
      .halt           (halt[g]),
      .pc_cur         (pc_cur[g]),
      .pc_saved       (pc_saved[g]),
      .pc_saved_valid (pc_saved_valid[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h", nm, g, act, exp);
    end
  endtask

  // Reference model: byte array per instance, response age since acceptance
  logic [7:0]       mb [2][256];
  logic [1:0]       busy;
  int               age [2];
  logic [1:0][31:0] exp_rdata, psv;
  logic [1:0]       exp_err, pv, ph;

  function automatic logic m_err(input logic [31:0] a, input logic [1:0] s);
    return (a >= 32'd256) || (s == 2'd3) || (s == 2'd1 && a[0]) ||
           (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] m_read(input int g, input logic [31:0] a,
                                         input logic [1:0] s, input logic u);
    logic [31:0] v;
    int n;
    n = 1 << s;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mb[g][int'(a[7:0]) + i]) << (8 * i));
    if (!u && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!u && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      exp_rdata <= '0;
      exp_err   <= '0;
      psv       <= '0;
      pv        <= '0;
      ph        <= '0;
      for (int g = 0; g < 2; g++) age[g] <= 0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        ph[g] <= halt[g];
        if (halt[g] && !ph[g]) begin
          psv[g] <= pc_cur[g];
          pv[g]  <= 1'b1;
        end
        if (busy[g]) begin
          if (age[g] >= lat_of(g) - 1 && rsp_ready[g]) busy[g] <= 1'b0;
          else if (age[g] < lat_of(g)) age[g] <= age[g] + 1;
        end else if (req_valid[g]) begin
          busy[g]      <= 1'b1;
          age[g]       <= 0;
          exp_err[g]   <= m_err(req_addr[g], req_size[g]);
          exp_rdata[g] <= (req_we[g] || m_err(req_addr[g], req_size[g])) ? 32'h0 :
                          m_read(g, req_addr[g], req_size[g], req_unsigned[g]);
          if (req_we[g] && !m_err(req_addr[g], req_size[g])) begin
            for (int i = 0; i < (1 << req_size[g]); i++)
              mb[g][int'(req_addr[g][7:0]) + i] <= req_wdata[g][8*i +: 8];
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        chk(g, "rst_req_ready", 32'(req_ready[g]), 32'd1);
        chk(g, "rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
        chk(g, "rst_rsp_rdata", rsp_rdata[g], 32'd0);
        chk(g, "rst_rsp_err", 32'(rsp_err[g]), 32'd0);
        chk(g, "rst_pc_saved", pc_saved[g], 32'd0);
        chk(g, "rst_pc_saved_valid", 32'(pc_saved_valid[g]), 32'd0);
      end else begin
        chk(g, "req_ready", 32'(req_ready[g]), 32'(!busy[g]));
        chk(g, "rsp_valid", 32'(rsp_valid[g]), 32'(busy[g] && (age[g] >= lat_of(g) - 1)));
        if (busy[g] && (age[g] >= lat_of(g) - 1)) begin
          chk(g, "rsp_rdata", rsp_rdata[g], exp_rdata[g]);
          chk(g, "rsp_err", 32'(rsp_err[g]), 32'(exp_err[g]));
        end
        chk(g, "pc_saved", pc_saved[g], psv[g]);
        chk(g, "pc_saved_valid", 32'(pc_saved_valid[g]), 32'(pv[g]));
      end
    end
  end

  // One request/response transaction; ls = negedges from acceptance to rsp_valid
  task automatic do_req(input int g, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wd,
                        input bit rnd_rdy, input int stall,
                        output logic [31:0] rd, output logic er, output int ls);
    int t, nst;
    bit got, first;
    logic [31:0] rd0;
    @(negedge clk);
    req_valid[g] = 1'b1; req_we[g] = we; req_addr[g] = addr;
    req_size[g] = size; req_unsigned[g] = uns; req_wdata[g] = wd;
    rsp_ready[g] = (stall > 0) ? 1'b0 : 1'b1;
    t = 0;
    while (!req_ready[g] && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk(g, "req_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid[g] = 1'b0;
    t = 0; nst = 0; got = 0; first = 1; ls = 0; rd = '0; er = 1'b0; rd0 = '0;
    while (!got && t < 200) begin
      t++;
      if (rsp_valid[g]) begin
        if (first) begin
          ls = t; first = 0; rd0 = rsp_rdata[g];
        end else if (nst > 0) begin
          chk(g, "stall_rdata_stable", rsp_rdata[g], rd0);
          chk(g, "stall_req_ready", 32'(req_ready[g]), 32'd0);
        end
        if (nst < stall) begin
          rsp_ready[g] = 1'b0; nst++;
        end else begin
          rsp_ready[g] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rsp_ready[g]) begin
          got = 1; rd = rsp_rdata[g]; er = rsp_err[g];
        end
      end
      if (!got) @(negedge clk);
    end
    if (!got) chk(g, "rsp_timeout", 32'd0, 32'd1);
    @(negedge clk);
    rsp_ready[g] = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic er;
    int ls;
    logic [1:0] s;
    rst_n = 1'b1;
    req_valid = '0; req_we = '0; req_unsigned = '0; req_addr = '0;
    req_size = '0; req_wdata = '0; rsp_ready = '1; halt = '0; pc_cur = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk(0, "lit_rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk(1, "lit_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    rst_n = 1'b1;

    for (int g = 0; g < 2; g++)
      for (int w = 0; w < 64; w++)
        do_req(g, 1'b1, 32'(w * 4), 2'd2, 1'b0, $urandom, 1'b0, 0, rd, er, ls);

    // Word write/read with single-cycle latency
    do_req(0, 1'b1, 32'h08, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 0, rd, er, ls);
    do_req(0, 1'b0, 32'h08, 2'd2, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_lat1", 32'(ls), 32'd1);
    chk(0, "lit_word_rd", rd, 32'hDEADBEEF);
    chk(0, "lit_word_err", 32'(er), 32'd0);

    // Byte/half merge and extension
    do_req(0, 1'b1, 32'h08, 2'd2, 1'b0, 32'h11223344, 1'b0, 0, rd, er, ls);
    do_req(0, 1'b1, 32'h09, 2'd0, 1'b0, 32'hABCDEF80, 1'b0, 0, rd, er, ls);
    do_req(0, 1'b0, 32'h08, 2'd2, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_byte_merge", rd, 32'h11228044);
    do_req(0, 1'b0, 32'h09, 2'd0, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_byte_signed", rd, 32'hFFFFFF80);
    do_req(0, 1'b0, 32'h09, 2'd0, 1'b1, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_byte_unsigned", rd, 32'h00000080);
    do_req(0, 1'b1, 32'h0A, 2'd1, 1'b0, 32'h55558001, 1'b0, 0, rd, er, ls);
    do_req(0, 1'b0, 32'h0A, 2'd1, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_half_signed", rd, 32'hFFFF8001);
    do_req(0, 1'b0, 32'h08, 2'd2, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_half_merge", rd, 32'h80018044);

    // Faulting accesses leave memory untouched
    do_req(0, 1'b1, 32'h00, 2'd2, 1'b0, 32'hA5A5A5A5, 1'b0, 0, rd, er, ls);
    do_req(0, 1'b1, 32'h04, 2'd2, 1'b0, 32'h5A5A5A5A, 1'b0, 0, rd, er, ls);
    do_req(0, 1'b0, 32'h03, 2'd1, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_mis_half_err", 32'(er), 32'd1);
    chk(0, "lit_mis_half_rd", rd, 32'h0);
    do_req(0, 1'b1, 32'h06, 2'd2, 1'b0, 32'hFFFFFFFF, 1'b0, 0, rd, er, ls);
    chk(0, "lit_mis_word_err", 32'(er), 32'd1);
    do_req(0, 1'b1, 32'h100, 2'd2, 1'b0, 32'hFFFFFFFF, 1'b0, 0, rd, er, ls);
    chk(0, "lit_oor_err", 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h00, 2'd3, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_size3_err", 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h04, 2'd2, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_unchanged_04", rd, 32'h5A5A5A5A);
    do_req(0, 1'b0, 32'h00, 2'd2, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(0, "lit_unchanged_00", rd, 32'hA5A5A5A5);

    // Latency 3 with a five-cycle response stall
    do_req(1, 1'b1, 32'h10, 2'd2, 1'b0, 32'h0BADCAFE, 1'b0, 0, rd, er, ls);
    do_req(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 5, rd, er, ls);
    chk(1, "lit_lat3", 32'(ls), 32'd3);
    chk(1, "lit_stall_rd", rd, 32'h0BADCAFE);
    chk(1, "lit_ready_after_hs", 32'(req_ready[1]), 32'd1);

    // Halt edge capture
    @(negedge clk);
    chk(0, "lit_pcv_before", 32'(pc_saved_valid[0]), 32'd0);
    halt[0] = 1'b0; pc_cur[0] = 32'h40;
    @(negedge clk); halt[0] = 1'b1;
    @(negedge clk);
    chk(0, "lit_pc_first", pc_saved[0], 32'h40);
    chk(0, "lit_pcv_first", 32'(pc_saved_valid[0]), 32'd1);
    pc_cur[0] = 32'h44;
    repeat (2) @(negedge clk);
    chk(0, "lit_pc_held", pc_saved[0], 32'h40);
    halt[0] = 1'b0;
    @(negedge clk); halt[0] = 1'b1; pc_cur[0] = 32'h80;
    @(negedge clk);
    chk(0, "lit_pc_second", pc_saved[0], 32'h80);
    halt[0] = 1'b0;

    // Randomized traffic with random response back-pressure
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 80; k++) begin
        s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) a = $urandom;
        else begin
          a = 32'($urandom_range(0, 255));
          if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~((32'd1 << s) - 32'd1);
        end
        do_req(g, 1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom,
               1'b1, 0, rd, er, ls);
      end
    end

    // Random halt/pc activity on both instances
    repeat (40) begin
      @(negedge clk);
      halt = 2'($urandom); pc_cur[0] = $urandom; pc_cur[1] = $urandom;
    end
    @(negedge clk); halt = '0;

    // Reset during WAIT of an accepted write
    @(negedge clk);
    chk(1, "lit_idle_before_rst", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
    req_size[1] = 2'd2; req_wdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    #2;
    req_valid[1] = 1'b0;
    chk(1, "lit_in_wait", 32'(req_ready[1]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk(1, "lit_async_req_ready", 32'(req_ready[1]), 32'd1);
    chk(1, "lit_async_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk(1, "lit_async_pcv", 32'(pc_saved_valid[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(1, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 1'b0, 0, rd, er, ls);
    chk(1, "lit_rst_write_kept", rd, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
